// File: rtl/char_seq_pkg.sv
// Shared codes and FSM encoding for the character sequencer.
// The spike-count option is enabled by defining CHAR_SEQ_SPIKE_CNT_EN.
package char_seq_pkg;

    localparam logic [1:0] CHAR_A = 2'b00;
    localparam logic [1:0] CHAR_J = 2'b01;
    localparam logic [1:0] CHAR_N = 2'b10;
    localparam logic [1:0] CHAR_X = 2'b11;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PRESENT = 2'd1;
    localparam logic [1:0] ST_REST    = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE    = ST_IDLE,
        S_PRESENT = ST_PRESENT,
        S_REST    = ST_REST,
        S_DONE    = ST_DONE
    } state_t;

endpackage

// File: rtl/char_seq_if.sv
// Host/generator-side bundle of the character sequencer.
// Spike-count signals exist only when CHAR_SEQ_SPIKE_CNT_EN is defined.
interface char_seq_if #(
    parameter int MAX_CHARS = 8,
    parameter int CNT_W     = 16
`ifdef CHAR_SEQ_SPIKE_CNT_EN
    , parameter int SPIKE_W = 8
`endif
);
    localparam int IDX_W = $clog2(MAX_CHARS);
    localparam int LEN_W = IDX_W + 1;

    logic                   start;
    logic                   abort;
    logic [2*MAX_CHARS-1:0] seq_data;
    logic [LEN_W-1:0]       seq_len;
    logic [CNT_W-1:0]       hold_cycles;
    logic [CNT_W-1:0]       rest_cycles;
    logic [1:0]             char_select;
    logic                   pwm_en;
    logic                   busy;
    logic                   done;
    logic [IDX_W-1:0]       cur_idx;
`ifdef CHAR_SEQ_SPIKE_CNT_EN
    logic                   spike_in;
    logic [SPIKE_W-1:0]     spike_count;
    logic                   count_valid;
    logic [IDX_W-1:0]       count_idx;
`endif

    modport master (
        output start, abort, seq_data, seq_len, hold_cycles, rest_cycles,
        input  char_select, pwm_en, busy, done, cur_idx
`ifdef CHAR_SEQ_SPIKE_CNT_EN
        , output spike_in
        , input  spike_count, count_valid, count_idx
`endif
    );

    modport slave (
        input  start, abort, seq_data, seq_len, hold_cycles, rest_cycles,
        output char_select, pwm_en, busy, done, cur_idx
`ifdef CHAR_SEQ_SPIKE_CNT_EN
        , input  spike_in
        , output spike_count, count_valid, count_idx
`endif
    );

endinterface

// File: rtl/char_seq_timer.sv
// Loadable down-counter with a registered zero flag, shared by the hold and rest phases.
module char_seq_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    // Zero is registered alongside the count so the FSM sees it without a compare path.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            zero <= 1'b1;
        end else if (load) begin
            cnt  <= load_val;
            zero <= (load_val == '0);
        end else if (en && !zero) begin
            cnt  <= cnt - CNT_W'(1);
            zero <= (cnt == CNT_W'(1));
        end
    end

endmodule

// File: rtl/char_seq_ctrl.sv
// Plays a latched list of characters into the pixel generator with hold/rest windows.
// Defining CHAR_SEQ_SPIKE_CNT_EN adds a per-window spike counter.
module char_seq_ctrl
    import char_seq_pkg::*;
#(
    parameter int MAX_CHARS = 8,
    parameter int CNT_W     = 16
`ifdef CHAR_SEQ_SPIKE_CNT_EN
    , parameter int SPIKE_W = 8
`endif
) (
    input  logic     clk,
    input  logic     rst,
    char_seq_if.slave bus
);

    localparam int IDX_W = $clog2(MAX_CHARS);
    localparam int LEN_W = IDX_W + 1;
    localparam int SEQ_W = 2 * MAX_CHARS;

    state_t           state, state_n;
    logic [SEQ_W-1:0] seq_sh;
    logic [CNT_W-1:0] hold_m1_sh;
    logic [CNT_W-1:0] rest_sh;
    logic [IDX_W-1:0] idx, idx_n;
    logic [IDX_W-1:0] rem, rem_n;
    logic             latch;
    logic             tmr_load;
    logic             tmr_en;
    logic             tmr_zero;
    logic [CNT_W-1:0] tmr_val;
    logic [LEN_W-1:0] len_clamped;
    logic [CNT_W-1:0] hold_m1_in;
    logic [SEQ_W-1:0] seq_src;
    logic [1:0]       sel_n;
    logic             window_end;

    assign len_clamped = (bus.seq_len > LEN_W'(MAX_CHARS)) ? LEN_W'(MAX_CHARS) : bus.seq_len;
    assign hold_m1_in  = (bus.hold_cycles == '0) ? '0 : bus.hold_cycles - CNT_W'(1);
    assign seq_src     = latch ? bus.seq_data : seq_sh;
    assign sel_n       = seq_src[{idx_n, 1'b0} +: 2];
    assign window_end  = (state == S_PRESENT) && tmr_zero && !bus.abort;

    char_seq_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .en       (tmr_en),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // rem counts entries still to play after the current one, so idx can never pass len-1.
    always_comb begin
        state_n  = state;
        idx_n    = idx;
        rem_n    = rem;
        latch    = 1'b0;
        tmr_load = 1'b0;
        tmr_en   = 1'b0;
        tmr_val  = hold_m1_sh;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    latch = 1'b1;
                    if (len_clamped == '0) begin
                        state_n = S_DONE;
                    end else begin
                        state_n  = S_PRESENT;
                        idx_n    = '0;
                        rem_n    = IDX_W'(len_clamped - LEN_W'(1));
                        tmr_load = 1'b1;
                        tmr_val  = hold_m1_in;
                    end
                end
            end
            S_PRESENT: begin
                if (!tmr_zero) begin
                    tmr_en = 1'b1;
                end else if (rest_sh != '0) begin
                    state_n  = S_REST;
                    tmr_load = 1'b1;
                    tmr_val  = rest_sh - CNT_W'(1);
                end else if (rem != '0) begin
                    idx_n    = idx + IDX_W'(1);
                    rem_n    = rem - IDX_W'(1);
                    tmr_load = 1'b1;
                end else begin
                    state_n = S_DONE;
                end
            end
            S_REST: begin
                if (!tmr_zero) begin
                    tmr_en = 1'b1;
                end else if (rem != '0) begin
                    state_n  = S_PRESENT;
                    idx_n    = idx + IDX_W'(1);
                    rem_n    = rem - IDX_W'(1);
                    tmr_load = 1'b1;
                end else begin
                    state_n = S_DONE;
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
        if (bus.abort) begin
            state_n  = S_IDLE;
            idx_n    = idx;
            rem_n    = rem;
            latch    = 1'b0;
            tmr_load = 1'b0;
            tmr_en   = 1'b0;
        end
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_IDLE;
            idx             <= '0;
            rem             <= '0;
            seq_sh          <= '0;
            hold_m1_sh      <= '0;
            rest_sh         <= '0;
            bus.char_select <= CHAR_A;
            bus.pwm_en      <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.cur_idx     <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            rem   <= rem_n;
            if (latch) begin
                seq_sh     <= bus.seq_data;
                hold_m1_sh <= hold_m1_in;
                rest_sh    <= bus.rest_cycles;
            end
            if (state_n == S_PRESENT) begin
                bus.char_select <= sel_n;
            end
            bus.pwm_en  <= (state_n == S_PRESENT);
            bus.busy    <= (state_n == S_PRESENT) || (state_n == S_REST);
            bus.done    <= (state_n == S_DONE);
            bus.cur_idx <= idx_n;
        end
    end

`ifdef CHAR_SEQ_SPIKE_CNT_EN
    logic [SPIKE_W-1:0] acc;
    logic [SPIKE_W-1:0] acc_inc;

    assign acc_inc = (bus.spike_in && (acc != '1)) ? acc + SPIKE_W'(1) : acc;

    // The reported count includes the spike sampled on the window's final cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc             <= '0;
            bus.spike_count <= '0;
            bus.count_valid <= 1'b0;
            bus.count_idx   <= '0;
        end else begin
            bus.count_valid <= 1'b0;
            if (window_end) begin
                bus.spike_count <= acc_inc;
                bus.count_valid <= 1'b1;
                bus.count_idx   <= idx;
            end
            if ((state_n == S_PRESENT) && ((state != S_PRESENT) || window_end)) begin
                acc <= '0;
            end else if (state == S_PRESENT) begin
                acc <= acc_inc;
            end
        end
    end
`endif

endmodule

// File: tb/tb_char_seq_ctrl.sv
// Scoreboard bench for char_seq_ctrl: a per-cycle expected trace is queued at each start.
// Spike-count scenarios compile only when CHAR_SEQ_SPIKE_CNT_EN is defined.
module tb_char_seq_ctrl;
    import char_seq_pkg::*;

    typedef struct packed {
        logic       pwm;
        logic       busy;
        logic       done;
        logic [1:0] sel;
        logic [2:0] idx;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         checks = 0;
    int         passes = 0;
    exp_t       exp_q[$];
    logic [1:0] last_sel = CHAR_A;
    logic [2:0] last_idx = 3'd0;
`ifdef CHAR_SEQ_SPIKE_CNT_EN
    int         cnt_q[$];
    int         cidx_q[$];
`endif

`ifdef CHAR_SEQ_SPIKE_CNT_EN
    char_seq_if #(.MAX_CHARS(8), .CNT_W(16), .SPIKE_W(8)) bus();
    char_seq_ctrl #(.MAX_CHARS(8), .CNT_W(16), .SPIKE_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
`else
    char_seq_if #(.MAX_CHARS(8), .CNT_W(16)) bus();
    char_seq_ctrl #(.MAX_CHARS(8), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

    always #5 clk = ~clk;

    // Reference model: one record per cycle from the cycle after start through the done pulse.
    task automatic push_run(input logic [15:0] data, input int len, input int hold, input int rest);
        int n;
        int h;
        logic [1:0] sel;
        n = (len > 8) ? 8 : len;
        h = (hold == 0) ? 1 : hold;
        for (int k = 0; k < n; k++) begin
            sel = data[2*k +: 2];
            repeat (h) exp_q.push_back({1'b1, 1'b1, 1'b0, sel, 3'(k)});
            repeat (rest) exp_q.push_back({1'b0, 1'b1, 1'b0, sel, 3'(k)});
            last_sel = sel;
            last_idx = 3'(k);
        end
        exp_q.push_back({3'b001, last_sel, last_idx});
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.char_select !== 2'b00) $display("[TB] FAIL reset_sel: got %b, expected 00", bus.char_select);
        else passes++;
        checks++;
        if (bus.pwm_en !== 1'b0) $display("[TB] FAIL reset_pwm: got %b, expected 0", bus.pwm_en);
        else passes++;
        checks++;
        if (bus.busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b, expected 0", bus.busy);
        else passes++;
        checks++;
        if (bus.done !== 1'b0) $display("[TB] FAIL reset_done: got %b, expected 0", bus.done);
        else passes++;
        checks++;
        if (bus.cur_idx !== 3'd0) $display("[TB] FAIL reset_idx: got %0d, expected 0", bus.cur_idx);
        else passes++;
`ifdef CHAR_SEQ_SPIKE_CNT_EN
        checks++;
        if ({bus.spike_count, bus.count_valid, bus.count_idx} !== 12'd0)
            $display("[TB] FAIL reset_spike: got %h, expected 000", {bus.spike_count, bus.count_valid, bus.count_idx});
        else passes++;
`endif
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        exp_t e, o;
        int n, busy_cycles;
        bus.seq_data    = {8'h00, CHAR_X, CHAR_N, CHAR_J, CHAR_A};
        bus.seq_len     = 4'd4;
        bus.hold_cycles = 16'd3;
        bus.rest_cycles = 16'd2;
        push_run(16'h00E4, 4, 3, 2);
        n = exp_q.size();
        busy_cycles = 0;
        pulse_start();
        for (int i = 0; i < n; i++) begin
            e = exp_q.pop_front();
            o = {bus.pwm_en, bus.busy, bus.done, bus.char_select, bus.cur_idx};
            if (bus.busy) busy_cycles++;
            checks++;
            if (o !== e) $display("[TB] FAIL basic cyc%0d: got %b, expected %b", i, o, e);
            else passes++;
            @(negedge clk);
        end
        checks++;
        if (busy_cycles !== 20) $display("[TB] FAIL basic_busy_len: got %0d, expected 20", busy_cycles);
        else passes++;
    endtask

    task automatic test_no_gap();
        exp_t e, o;
        int n;
        bus.seq_data    = 16'h0006;
        bus.seq_len     = 4'd2;
        bus.hold_cycles = 16'd0;
        bus.rest_cycles = 16'd0;
        push_run(16'h0006, 2, 0, 0);
        n = exp_q.size();
        pulse_start();
        for (int i = 0; i < n; i++) begin
            e = exp_q.pop_front();
            o = {bus.pwm_en, bus.busy, bus.done, bus.char_select, bus.cur_idx};
            checks++;
            if (o !== e) $display("[TB] FAIL no_gap cyc%0d: got %b, expected %b", i, o, e);
            else passes++;
            @(negedge clk);
        end
    endtask

    task automatic test_len_bounds();
        exp_t e, o;
        int n;
        bus.seq_len = 4'd0;
        push_run(16'h0000, 0, 1, 1);
        pulse_start();
        e = exp_q.pop_front();
        o = {bus.pwm_en, bus.busy, bus.done, bus.char_select, bus.cur_idx};
        checks++;
        if (o !== e) $display("[TB] FAIL len0: got %b, expected %b", o, e);
        else passes++;
        @(negedge clk);
        checks++;
        if ({bus.pwm_en, bus.busy, bus.done} !== 3'b000)
            $display("[TB] FAIL len0_idle: got %b, expected 000", {bus.pwm_en, bus.busy, bus.done});
        else passes++;

        bus.seq_data    = 16'h1B1B;
        bus.seq_len     = 4'd12;
        bus.hold_cycles = 16'd1;
        bus.rest_cycles = 16'd1;
        push_run(16'h1B1B, 12, 1, 1);
        n = exp_q.size();
        pulse_start();
        for (int i = 0; i < n; i++) begin
            e = exp_q.pop_front();
            o = {bus.pwm_en, bus.busy, bus.done, bus.char_select, bus.cur_idx};
            checks++;
            if (o !== e) $display("[TB] FAIL clamp cyc%0d: got %b, expected %b", i, o, e);
            else passes++;
            @(negedge clk);
        end
    endtask

    task automatic test_abort();
        exp_t e, o;
        int n;
        logic done_seen;
        bus.seq_data    = 16'h00E4;
        bus.seq_len     = 4'd4;
        bus.hold_cycles = 16'd3;
        bus.rest_cycles = 16'd1;
        push_run(16'h00E4, 4, 3, 1);
        pulse_start();
        for (int i = 0; i <= 8; i++) begin
            e = exp_q.pop_front();
            o = {bus.pwm_en, bus.busy, bus.done, bus.char_select, bus.cur_idx};
            checks++;
            if (o !== e) $display("[TB] FAIL abort_run cyc%0d: got %b, expected %b", i, o, e);
            else passes++;
            if (i < 8) @(negedge clk);
        end
        exp_q.delete();
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        last_sel = CHAR_N;
        last_idx = 3'd2;
        o = {bus.pwm_en, bus.busy, bus.done, bus.char_select, bus.cur_idx};
        checks++;
        if (o !== {3'b000, last_sel, last_idx}) $display("[TB] FAIL abort_next: got %b, expected %b", o, {3'b000, last_sel, last_idx});
        else passes++;
        done_seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus.done || bus.busy) done_seen = 1'b1;
        end
        checks++;
        if (done_seen !== 1'b0) $display("[TB] FAIL abort_quiet: got %b, expected 0", done_seen);
        else passes++;

        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        checks++;
        if ({bus.pwm_en, bus.busy} !== 2'b00) $display("[TB] FAIL start_with_abort: got %b, expected 00", {bus.pwm_en, bus.busy});
        else passes++;

        push_run(16'h00E4, 4, 3, 1);
        n = exp_q.size();
        pulse_start();
        for (int i = 0; i < n; i++) begin
            e = exp_q.pop_front();
            o = {bus.pwm_en, bus.busy, bus.done, bus.char_select, bus.cur_idx};
            checks++;
            if (o !== e) $display("[TB] FAIL replay cyc%0d: got %b, expected %b", i, o, e);
            else passes++;
            @(negedge clk);
        end
    endtask

    task automatic test_busy_start_and_reset();
        exp_t e, o;
        bus.seq_data    = 16'h00B1;
        bus.seq_len     = 4'd4;
        bus.hold_cycles = 16'd2;
        bus.rest_cycles = 16'd3;
        push_run(16'h00B1, 4, 2, 3);
        pulse_start();
        for (int i = 0; i <= 8; i++) begin
            e = exp_q.pop_front();
            o = {bus.pwm_en, bus.busy, bus.done, bus.char_select, bus.cur_idx};
            checks++;
            if (o !== e) $display("[TB] FAIL busy_start cyc%0d: got %b, expected %b", i, o, e);
            else passes++;
            if (i == 3) bus.start = 1'b1;
            if (i == 4) bus.start = 1'b0;
            if (i < 8) @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        o = {bus.pwm_en, bus.busy, bus.done, bus.char_select, bus.cur_idx};
        checks++;
        if (o !== 8'd0) $display("[TB] FAIL mid_rest_reset: got %b, expected 00000000", o);
        else passes++;
        rst = 1'b0;
        exp_q.delete();
        last_sel = CHAR_A;
        last_idx = 3'd0;
        @(negedge clk);
        o = {bus.pwm_en, bus.busy, bus.done, bus.char_select, bus.cur_idx};
        checks++;
        if (o !== 8'd0) $display("[TB] FAIL after_reset: got %b, expected 00000000", o);
        else passes++;
    endtask

`ifdef CHAR_SEQ_SPIKE_CNT_EN
    task automatic test_spike_count();
        logic [9:0] pat;
        int exp_cnt, exp_idx;
        pat = 10'b0100101010;
        bus.seq_data    = {14'd0, CHAR_X};
        bus.seq_len     = 4'd1;
        bus.hold_cycles = 16'd10;
        bus.rest_cycles = 16'd0;
        cnt_q.push_back(4);
        cidx_q.push_back(0);
        pulse_start();
        for (int i = 0; i < 40 && !bus.count_valid; i++) begin
            bus.spike_in = (i < 10) ? pat[i] : 1'b0;
            @(negedge clk);
        end
        bus.spike_in = 1'b0;
        exp_cnt = cnt_q.pop_front();
        exp_idx = cidx_q.pop_front();
        checks++;
        if (bus.count_valid !== 1'b1) $display("[TB] FAIL spike4_valid: got %b, expected 1", bus.count_valid);
        else passes++;
        checks++;
        if ({bus.spike_count, bus.count_idx} !== {8'(exp_cnt), 3'(exp_idx)})
            $display("[TB] FAIL spike4: got cnt=%0d idx=%0d, expected cnt=%0d idx=%0d", bus.spike_count, bus.count_idx, exp_cnt, exp_idx);
        else passes++;
        repeat (3) @(negedge clk);

        bus.hold_cycles = 16'd300;
        cnt_q.push_back(255);
        cidx_q.push_back(0);
        bus.spike_in = 1'b1;
        pulse_start();
        for (int i = 0; i < 400 && !bus.count_valid; i++) @(negedge clk);
        bus.spike_in = 1'b0;
        exp_cnt = cnt_q.pop_front();
        exp_idx = cidx_q.pop_front();
        checks++;
        if (bus.count_valid !== 1'b1) $display("[TB] FAIL spike_sat_valid: got %b, expected 1", bus.count_valid);
        else passes++;
        checks++;
        if ({bus.spike_count, bus.count_idx} !== {8'(exp_cnt), 3'(exp_idx)})
            $display("[TB] FAIL spike_sat: got cnt=%0d idx=%0d, expected cnt=%0d idx=%0d", bus.spike_count, bus.count_idx, exp_cnt, exp_idx);
        else passes++;
        repeat (3) @(negedge clk);
    endtask
`endif

    initial begin
        bus.start       = 1'b0;
        bus.abort       = 1'b0;
        bus.seq_data    = '0;
        bus.seq_len     = '0;
        bus.hold_cycles = '0;
        bus.rest_cycles = '0;
`ifdef CHAR_SEQ_SPIKE_CNT_EN
        bus.spike_in    = 1'b0;
`endif
        $display("[TB] char_seq_ctrl bench starting");
        test_reset();
        test_basic();
        test_no_gap();
        test_len_bounds();
        test_abort();
        test_busy_start_and_reset();
`ifdef CHAR_SEQ_SPIKE_CNT_EN
        test_spike_count();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
